// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the op-code width and the op-code encodings decoded by pc_seq_unit.
package pc_seq_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD   = 3'b000;
    localparam logic [OP_W-1:0] OP_INC    = 3'b001;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'b010;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'b011;
    localparam logic [OP_W-1:0] OP_CALL   = 3'b100;
    localparam logic [OP_W-1:0] OP_RET    = 3'b101;
endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for CALL/RET.
// Ports:
//   clk, reset (async, active-low)
//   push, pop  - requests; push ignored when full, pop ignored when empty
//   din        - address to push
//   dout       - current top entry (undefined when empty)
//   depth      - entries currently held
//   full/empty - depth == STACK_DEPTH / depth == 0
module pc_ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              din,
    output logic [ADDR_W-1:0]              dout,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           full,
    output logic                           empty
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]     cnt;
    logic [PW-1:0]     wr_idx;
    logic [PW-1:0]     top_idx;

    assign wr_idx  = cnt[PW-1:0];
    // Top of stack sits one below the count; when empty this wraps and
    // the value is never used.
    assign top_idx = PW'(cnt - DW'(1));

    assign full  = (cnt == DW'(STACK_DEPTH));
    assign empty = (cnt == '0);
    assign depth = cnt;
    assign dout  = mem[top_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + DW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - DW'(1);
        end
    end

    // Storage needs no reset: only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end
endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: drives the fetch address each cycle.
// Supports hold, increment, absolute jump, signed relative branch and
// CALL/RET through a hardware return-address stack.
// Ports:
//   clk, reset (async, active-low), stall (holds everything)
//   op, target, offset - operation and its operands, sampled on rising clk
//   pc_data            - registered program counter
//   stack_depth/full/empty - return-stack status
//   err_overflow/err_underflow - one-cycle pulses on CALL-full / RET-empty
// Build option: define PC_TRAP_EN to load TRAP_VEC into the PC on a stack
// error; otherwise the PC holds and only the error pulse is raised.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                STEP        = 1,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC    = '1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [OP_W-1:0]              op,
    input  logic [ADDR_W-1:0]            target,
    input  logic [ADDR_W-1:0]            offset,
    output logic [ADDR_W-1:0]            pc_data,
    output logic [$clog2(STACK_DEPTH):0] stack_depth,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         err_overflow,
    output logic                         err_underflow
);
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] stack_top;
    logic              push;
    logic              pop;
    logic              ovf_next;
    logic              unf_next;

    assign ret_addr = pc_data + ADDR_W'(STEP);

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .dout  (stack_top),
        .depth (stack_depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        pc_next  = pc_data;
        push     = 1'b0;
        pop      = 1'b0;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (!stall) begin
            case (op)
                OP_INC:    pc_next = pc_data + ADDR_W'(STEP);
                OP_JUMP:   pc_next = target;
                // Equal-width add is the same as adding the sign-extended
                // displacement modulo 2^ADDR_W.
                OP_BRANCH: pc_next = pc_data + offset;
                OP_CALL: begin
                    if (!stack_full) begin
                        push    = 1'b1;
                        pc_next = target;
                    end else begin
                        ovf_next = 1'b1;
`ifdef PC_TRAP_EN
                        pc_next  = TRAP_VEC;
`endif
                    end
                end
                OP_RET: begin
                    if (!stack_empty) begin
                        pop     = 1'b1;
                        pc_next = stack_top;
                    end else begin
                        unf_next = 1'b1;
`ifdef PC_TRAP_EN
                        pc_next  = TRAP_VEC;
`endif
                    end
                end
                default: pc_next = pc_data; // HOLD and reserved codes
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_data       <= RESET_VEC;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            pc_data       <= pc_next;
            err_overflow  <= ovf_next;
            err_underflow <= unf_next;
        end
    end
endmodule
